tpu_layer_seq: RTL

Programmable layer sequencer for the TPU. It replaces the fixed conv/FC ordering with a table of up to `MAX_LAYERS` entries that software loads before a run. For each layer it optionally requests a DMA weight/ifmap load, then starts the core in conv or FC mode and waits on a selectable done bit. It sits between the AXI control registers, the DMA engine and the TPU core, and adds abort, a watchdog timeout and an error flag.

---
 rtl/tpu_layer_seq_if.sv | 47 ++++
 rtl/tpu_layer_seq.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/tpu_layer_seq_if.sv
// Control/DMA/core-facing signal bundle of the layer sequencer.
// The sequencer uses the slave view; the surrounding system (or a bench) uses master.
interface tpu_layer_seq_if #(
  parameter int MAX_LAYERS = 8,
  parameter int DONE_W     = 17,
  parameter int OFMAP_W    = 5,
  parameter int CH_W       = 6,
  parameter int NIN_W      = 9,
  parameter int NOUT_W     = 7
);
  localparam int LW  = $clog2(MAX_LAYERS);
  localparam int DSW = $clog2(DONE_W);
  localparam int E   = 2 + DSW + OFMAP_W + CH_W + NIN_W + NOUT_W;

  logic              cfg_we_i;
  logic [LW-1:0]     cfg_addr_i;
  logic [E-1:0]      cfg_data_i;
  logic [LW:0]       num_layers_i;
  logic              start_i;
  logic              abort_i;
  logic              start_dma_o;
  logic [LW-1:0]     nth_layer_o;
  logic              dma_done_i;
  logic [OFMAP_W-1:0] ofmap_size_o;
  logic [CH_W-1:0]   ifmap_ch_o;
  logic [NIN_W-1:0]  in_node_num_o;
  logic [NOUT_W-1:0] out_node_num_o;
  logic [DONE_W-1:0] done_i;
  logic [1:0]        start_core_o;
  logic              busy_o;
  logic              cnn_done_o;
  logic              err_o;

  modport master (
    output cfg_we_i, cfg_addr_i, cfg_data_i, num_layers_i, start_i, abort_i,
           dma_done_i, done_i,
    input  start_dma_o, nth_layer_o, ofmap_size_o, ifmap_ch_o, in_node_num_o,
           out_node_num_o, start_core_o, busy_o, cnn_done_o, err_o
  );

  modport slave (
    input  cfg_we_i, cfg_addr_i, cfg_data_i, num_layers_i, start_i, abort_i,
           dma_done_i, done_i,
    output start_dma_o, nth_layer_o, ofmap_size_o, ifmap_ch_o, in_node_num_o,
           out_node_num_o, start_core_o, busy_o, cnn_done_o, err_o
  );
endinterface

// File: rtl/tpu_layer_seq.sv
// Table-driven TPU layer sequencer: per layer, optional DMA load, then a conv/FC
// core run gated on a selectable done bit, with abort, watchdog and sticky error.
module tpu_layer_seq #(
  parameter int MAX_LAYERS = 8,
  parameter int DONE_W     = 17,
  parameter int OFMAP_W    = 5,
  parameter int CH_W       = 6,
  parameter int NIN_W      = 9,
  parameter int NOUT_W     = 7,
  parameter int TIMEOUT    = 1000000
) (
  input logic          clk,
  input logic          rst,
  tpu_layer_seq_if.slave bus
);
  localparam int LW  = $clog2(MAX_LAYERS);
  localparam int DSW = $clog2(DONE_W);
  localparam int WDW = $clog2(TIMEOUT);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);
  localparam logic [LW:0]    MAX_CNT = (LW+1)'(MAX_LAYERS);

  typedef struct packed {
    logic               is_fc;
    logic               dma_en;
    logic [DSW-1:0]     done_sel;
    logic [OFMAP_W-1:0] ofmap;
    logic [CH_W-1:0]    ch;
    logic [NIN_W-1:0]   nin;
    logic [NOUT_W-1:0]  nout;
  } entry_t;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_DMA_REQ, S_DMA_WAIT, S_CORE_REQ, S_CORE_WAIT, S_NEXT, S_FIN
  } state_t;

  state_t        state, next;
  entry_t        tbl [MAX_LAYERS];
  entry_t        cur;
  logic [LW-1:0] idx;
  logic [LW:0]   count;
  logic [WDW-1:0] wd;
  logic          start_ok, start_bad, timeout_fire, done_hit, last_layer, wd_expired;

  // NOTE: the layer table is plain storage loaded by software before a run, so it
  // has no reset; resetting it would turn a RAM into a large flop array.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && bus.cfg_we_i && ({1'b0, bus.cfg_addr_i} < MAX_CNT))
      tbl[bus.cfg_addr_i] <= entry_t'(bus.cfg_data_i);
  end

  // Writes are blocked outside IDLE, so the entry under idx is stable for the whole layer.
  assign cur        = tbl[idx];
  assign last_layer = ({1'b0, idx} == count - 1'b1);
  assign wd_expired = (wd == WD_LAST);

  // A done_sel beyond the vector never matches, leaving the watchdog to end the wait.
  always_comb begin
    done_hit = 1'b0;
    if (int'(cur.done_sel) < DONE_W)
      done_hit = bus.done_i[cur.done_sel];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next;
  end

  // NOTE: every signal assigned in this block gets a default first, so no path
  // can leave one unassigned and infer a latch.
  always_comb begin
    next         = state;
    start_ok     = 1'b0;
    start_bad    = 1'b0;
    timeout_fire = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (bus.start_i) begin
          if (bus.num_layers_i != '0 && bus.num_layers_i <= MAX_CNT) begin
            start_ok = 1'b1;
            next     = S_LOAD;
          end else begin
            start_bad = 1'b1;
          end
        end
      end
      S_LOAD:     next = cur.dma_en ? S_DMA_REQ : S_CORE_REQ;
      S_DMA_REQ:  next = S_DMA_WAIT;
      S_DMA_WAIT: begin
        if (bus.dma_done_i) next = S_CORE_REQ;
        else if (wd_expired) begin
          next         = S_IDLE;
          timeout_fire = 1'b1;
        end
      end
      S_CORE_REQ:  next = S_CORE_WAIT;
      S_CORE_WAIT: begin
        if (done_hit) next = S_NEXT;
        else if (wd_expired) begin
          next         = S_IDLE;
          timeout_fire = 1'b1;
        end
      end
      S_NEXT:  next = last_layer ? S_FIN : S_LOAD;
      S_FIN:   next = S_IDLE;
      default: next = S_IDLE;
    endcase
    // Abort overrides everything, including a completion arriving the same cycle.
    if (state != S_IDLE && bus.abort_i) begin
      next         = S_IDLE;
      timeout_fire = 1'b0;
    end
  end

  // Pulses are registered from the next state so they line up with the state they name.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx                <= '0;
      count              <= '0;
      wd                 <= '0;
      bus.start_dma_o    <= 1'b0;
      bus.start_core_o   <= 2'b00;
      bus.busy_o         <= 1'b0;
      bus.cnn_done_o     <= 1'b0;
      bus.err_o          <= 1'b0;
      bus.nth_layer_o    <= '0;
      bus.ofmap_size_o   <= '0;
      bus.ifmap_ch_o     <= '0;
      bus.in_node_num_o  <= '0;
      bus.out_node_num_o <= '0;
    end else begin
      bus.start_dma_o  <= (next == S_DMA_REQ);
      bus.start_core_o <= (next == S_CORE_REQ) ? (cur.is_fc ? 2'b10 : 2'b01) : 2'b00;
      bus.busy_o       <= (next != S_IDLE);
      bus.cnn_done_o   <= (next == S_FIN);

      if (start_ok) begin
        count     <= bus.num_layers_i;
        idx       <= '0;
        bus.err_o <= 1'b0;
      end
      if (start_bad || timeout_fire) bus.err_o <= 1'b1;
      if (state == S_NEXT && next == S_LOAD) idx <= idx + 1'b1;

      if (state == S_LOAD) begin
        bus.nth_layer_o    <= idx;
        bus.ofmap_size_o   <= cur.ofmap;
        bus.ifmap_ch_o     <= cur.ch;
        bus.in_node_num_o  <= cur.nin;
        bus.out_node_num_o <= cur.nout;
      end

      if ((next == S_DMA_WAIT || next == S_CORE_WAIT) && next != state) wd <= '0;
      else if (state == S_DMA_WAIT || state == S_CORE_WAIT)             wd <= wd + 1'b1;
    end
  end
endmodule
